// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register file,
// decode stage and the register dump reader.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_wrap_index_counter.sv
// Register index walker: loads a first/last pair, steps with
// wrap at NUM_REGS-1, and flags when the current index is last.
module wrap_index_counter #(
    parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] idx,
    output logic              at_last
);

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(NUM_REGS - 1);

    logic [ADDR_W-1:0] last_q;

    // Load the range on start, otherwise step the index with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            last_q <= '0;
        end else if (load) begin
            idx    <= first;
            last_q <= last;
        end else if (inc) begin
            idx <= (idx == MAX_IDX) ? '0 : idx + ADDR_W'(1);
        end
    end

    assign at_last = (idx == last_q);

endmodule

// File: rtl/regfile_dump.sv
// Sequential register file reader: walks an index range through
// one read port and streams (index, value) over valid/ready.
module regfile_dump #(
    parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
    parameter int DATA_W   = cpu_pkg::REG_DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    import cpu_pkg::*;

    dump_state_t       state_q;
    dump_state_t       state_d;
    logic              load;
    logic              inc;
    logic              capture;
    logic              clr_valid;
    logic [ADDR_W-1:0] idx;
    logic              at_last;
    logic [ADDR_W-1:0] rd_addr_q;

    wrap_index_counter #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .inc     (inc),
        .first   (first_reg),
        .last    (last_reg),
        .idx     (idx),
        .at_last (at_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and control decode; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        inc       = 1'b0;
        capture   = 1'b0;
        clr_valid = 1'b0;
        if (abort) begin
            state_d   = IDLE;
            clr_valid = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        load    = 1'b1;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        clr_valid = 1'b1;
                        if (at_last) begin
                            state_d = DONE;
                        end else begin
                            inc     = 1'b1;
                            state_d = ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Capture the read word at the end of ISSUE; hold until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            rd_addr_q <= rd_addr;
            if (capture) begin
                out_data  <= rd_data;
                out_index <= idx;
                out_valid <= 1'b1;
            end else if (clr_valid) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign rd_addr = (state_q == ISSUE) ? idx : rd_addr_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a falling-edge-write
// register file model and hand-computed expected words.
module tb_regfile_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] rf [32];
    int n_chk;
    int n_fail;

    regfile_dump dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : rf[rd_addr];

    function automatic logic [31:0] exp_word(input logic [4:0] e);
        return (e == 5'd0) ? 32'd0 : rf[e];
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [4:0] f, input logic [4:0] l);
        start     = 1'b1;
        first_reg = f;
        last_reg  = l;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic scan(input logic [4:0] f,
                        input int nwords,
                        input string tag);
        int got;
        int dones;
        logic [4:0] e;
        got   = 0;
        dones = 0;
        e     = f;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                dones++;
                chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
                break;
            end
            if (out_valid && out_ready) begin
                chk({tag, "_idx"}, {27'd0, out_index}, {27'd0, e});
                chk({tag, "_data"}, out_data, exp_word(e));
                got++;
                e = (e == 5'd31) ? 5'd0 : e + 5'd1;
            end
            @(negedge clk);
        end
        chk({tag, "_count"}, got, nwords);
        chk({tag, "_dones"}, dones, 1);
        @(negedge clk);
        chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        chk({tag, "_valid_off"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rd_addr"}, {27'd0, rd_addr}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_index"}, {27'd0, out_index}, 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        first_reg = 5'd0;
        last_reg  = 5'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        rf[0] = 32'd0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_outs("reset");

        // full dump with latency check
        do_start(5'd0, 5'd31);
        chk("lat_valid_n1", {31'd0, out_valid}, 32'd0);
        chk("lat_busy_n1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("lat_valid_n2", {31'd0, out_valid}, 32'd1);
        chk("w0_data", out_data, 32'd0);
        scan(5'd0, 32, "full");

        // wrapped range
        do_start(5'd30, 5'd2);
        scan(5'd30, 5, "wrap");

        // single word with back-pressure
        out_ready = 1'b0;
        do_start(5'd7, 5'd7);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_index", {27'd0, out_index}, 32'd7);
            chk("bp_data", out_data, 32'h1000_0007);
            @(negedge clk);
        end
        out_ready = 1'b1;
        scan(5'd7, 1, "single");

        // abort at index 10
        do_start(5'd8, 5'd20);
        n = 0;
        while (!(out_valid && out_index == 5'd10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach", {31'd0, n < 100}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        do_start(5'd3, 5'd4);
        scan(5'd3, 2, "restart");

        // start while busy is ignored
        do_start(5'd2, 5'd6);
        n = 0;
        while (!(busy && !out_valid && rd_addr == 5'd4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("busy_start_reach", {31'd0, n < 100}, 32'd1);
        start     = 1'b1;
        first_reg = 5'd20;
        last_reg  = 5'd25;
        @(negedge clk);
        start     = 1'b0;
        scan(5'd4, 3, "ignore_start");

        // reset during ISSUE
        do_start(5'd1, 5'd31);
        n = 0;
        while (!(busy && !out_valid && rd_addr == 5'd3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", {31'd0, n < 100}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outs("mid_rst");

        // falling-edge write during ISSUE of index 9
        do_start(5'd8, 5'd10);
        n = 0;
        while (!(busy && !out_valid && rd_addr == 5'd9) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wr_reach", {31'd0, n < 100}, 32'd1);
        rf[9] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_idx9", {27'd0, out_index}, 32'd9);
        chk("wr_data9", out_data, 32'hDEAD_BEEF);
        scan(5'd9, 2, "wr");

        // write to r0 is not reflected
        do_start(5'd0, 5'd1);
        rf[0] = 32'hFFFF_FFFF;
        scan(5'd0, 2, "r0");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
